apb_regfile_completer: RTL and testbench

//  APB3 completer: bank of NUM_REGS 32-bit read/write registers mapped at BASE_ADDR, one register per byte offset.

---
 rtl/apb_regfile_completer.sv | 123 ++++++++++++
 tb/tb_apb_regfile_completer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_completer.sv
// APB3 completer exposing NUM_REGS 32-bit scratch/config registers at BASE_ADDR.
// Handshake: a transfer completes in the single cycle where psel & penable & pready are all high.
module apb_regfile_completer #(
   parameter logic [31:0] BASE_ADDR   = 32'h7000_0000,
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_STATES = 0
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic [1:0]  dbg_state
);

   localparam int IW = $clog2(NUM_REGS);

   typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        latch;
   logic [31:0] addr_q, wdata_q;
   logic        write_q;
   logic [31:0] regs_q [NUM_REGS];
   logic        hit, valid, enter_resp;
   logic [IW-1:0] idx;

   assign hit        = (addr_q[31:12] == BASE_ADDR[31:12]);
   assign valid      = hit && (addr_q[11:0] < 12'(NUM_REGS));
   assign idx        = addr_q[IW-1:0];
   assign enter_resp = (state_q == WAIT) && (state_d == RESP);
   assign dbg_state  = state_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = SETUP;
               latch   = 1'b1;
            end
         end
         SETUP: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (penable) begin
               state_d = WAIT;
               cnt_d   = 4'(WAIT_STATES);
            end
         end
         WAIT: begin
            // An abort during the wait window leaves no trace.
            if (!psel || !penable) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (!psel || !penable) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         write_q <= 1'b0;
      end else if (latch) begin
         addr_q  <= paddr;
         wdata_q <= pwdata;
         write_q <= pwrite;
      end
   end

   // The write lands only on the edge entering RESP, so a held RESP never rewrites.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'd0;
      end else if (enter_resp && write_q && valid) begin
         regs_q[idx] <= wdata_q;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= 32'd0;
      end else if (enter_resp) begin
         pready  <= 1'b1;
         pslverr <= !valid;
         prdata  <= (!write_q && valid) ? regs_q[idx] : 32'd0;
      end else if (state_d != RESP) begin
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= 32'd0;
      end
   end

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Bench for apb_regfile_completer: one instance with no wait states, one with three,
// driven through a shared bus with per-instance select.
module tb_apb_regfile_completer;

   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic        sel = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] paddr = 32'd0;
   logic [31:0] pwdata = 32'd0;

   logic        psel0, psel3;
   logic [31:0] prdata0, prdata3;
   logic        pready0, pready3, pslverr0, pslverr3;
   logic [1:0]  dbg0, dbg3;
   logic [31:0] prdata_s;
   logic        pready_s, pslverr_s;

   int total = 0;
   int bad   = 0;

   logic [31:0] mdl [2][16];

   always #5 pclk = ~pclk;

   assign psel0     = psel & ~sel;
   assign psel3     = psel & sel;
   assign prdata_s  = sel ? prdata3  : prdata0;
   assign pready_s  = sel ? pready3  : pready0;
   assign pslverr_s = sel ? pslverr3 : pslverr0;

   apb_regfile_completer #(.BASE_ADDR(32'h7000_0000), .NUM_REGS(16), .WAIT_STATES(0)) u_dut0 (
      .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
      .dbg_state(dbg0));

   apb_regfile_completer #(.BASE_ADDR(32'h7000_0000), .NUM_REGS(16), .WAIT_STATES(3)) u_dut3 (
      .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
      .dbg_state(dbg3));

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: a flat array per instance, addressed by the region/offset rules.
   function automatic void ref_access(input bit s, input bit wr, input logic [31:0] a,
                                      input logic [31:0] d, output logic [31:0] rd,
                                      output logic err);
      bit ok;
      int off;
      off = int'(a[11:0]);
      ok  = (a[31:12] == 20'h70000) && (off < 16);
      err = !ok;
      rd  = 32'd0;
      if (ok && wr)  mdl[s][off] = d;
      if (ok && !wr) rd = mdl[s][off];
   endfunction

   function automatic void ref_clear();
      for (int i = 0; i < 16; i++) begin
         mdl[0][i] = 32'd0;
         mdl[1][i] = 32'd0;
      end
   endfunction

   task automatic xfer(input bit s, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input int hold, output logic [31:0] rd, output logic err);
      int n;
      sel = s; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      tick();
      penable = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!pready_s && n < 40);
      check("latency", n, s ? 32'd5 : 32'd2);
      rd  = prdata_s;
      err = pslverr_s;
      pwdata = ~d;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_pready", pready_s, 1'b1);
         check("hold_prdata", prdata_s, rd);
      end
      psel = 1'b0; penable = 1'b0;
      tick();
      check("drop_pready", pready_s, 1'b0);
      check("drop_prdata", prdata_s, 32'd0);
      check("drop_pslverr", pslverr_s, 1'b0);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] er, input bit ee);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [31:0] rd, mrd;
      logic        err, merr;
      int          fill_v [11];
      fill_v = '{11, 20, 25, 71, 76, 85, 83, 65, 80, 72, 65};
      ref_clear();

      repeat (3) tick();
      check("por_pready", pready0 | pready3, 1'b0);
      check("por_state", {dbg0, dbg3}, 4'd0);
      presetn = 1'b1;
      tick();

      // Reset held for 5 cycles while instance 3 sits in its wait window.
      xfer(1'b0, 1'b1, 32'h7000_0000, 32'h1234, 0, rd, err);
      xfer(1'b1, 1'b1, 32'h7000_0000, 32'h5678, 0, rd, err);
      sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h7000_0003; pwdata = 32'h99;
      tick();
      penable = 1'b1;
      tick(); tick();
      check("pre_reset_in_wait", dbg3, 2'd2);
      presetn = 1'b0;
      #1;
      check("async_reset_state", dbg3, 2'd0);
      repeat (5) begin
         tick();
         check("rst_pready", pready3, 1'b0);
         check("rst_pslverr", pslverr3, 1'b0);
         check("rst_prdata", prdata3, 32'd0);
      end
      psel = 1'b0; penable = 1'b0;
      presetn = 1'b1;
      tick();
      ref_clear();
      xfer(1'b0, 1'b0, 32'h7000_0000, 32'd0, 0, rd, err);
      check("post_rst_rd0", rd, 32'd0);
      xfer(1'b1, 1'b0, 32'h7000_0000, 32'd0, 0, rd, err);
      check("post_rst_rd3", rd, 32'd0);
      xfer(1'b1, 1'b0, 32'h7000_0003, 32'd0, 0, rd, err);
      check("post_rst_discard", rd, 32'd0);

      // Directed table on the zero-wait instance.
      add(1, 32'h7000_0000, 32'd6, 32'd0, 0);
      add(0, 32'h7000_0000, 32'd0, 32'd6, 0);
      add(1, 32'h7000_0004, 32'd9, 32'd0, 0);
      add(0, 32'h7000_0004, 32'd0, 32'd9, 0);
      add(0, 32'h7000_0000, 32'd0, 32'd6, 0);
      for (int i = 0; i < 11; i++) add(1, 32'h7000_0005 + i, fill_v[i], 32'd0, 0);
      for (int i = 0; i < 11; i++) add(0, 32'h7000_0005 + i, 32'd0, fill_v[i], 0);
      add(1, 32'h7000_0010, 32'hDEAD, 32'd0, 1);
      add(1, 32'h6000_0000, 32'hDEAD, 32'd0, 1);
      add(0, 32'h7000_0010, 32'd0, 32'd0, 1);
      add(0, 32'h6000_0000, 32'd0, 32'd0, 1);
      add(0, 32'h7000_0000, 32'd0, 32'd6, 0);
      add(0, 32'h7000_000F, 32'd0, 32'd65, 0);
      for (int i = 0; i < tbl.size(); i++) begin
         ref_access(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, mrd, merr);
         xfer(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 0, rd, err);
         check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
         if (!tbl[i].wr) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      end

      // Held response with changing pwdata must commit exactly the latched value once.
      ref_access(1'b1, 1'b1, 32'h7000_0008, 32'h1111_2222, mrd, merr);
      xfer(1'b1, 1'b1, 32'h7000_0008, 32'h1111_2222, 4, rd, err);
      check("hold_wr_err", err, 1'b0);
      xfer(1'b1, 1'b0, 32'h7000_0008, 32'd0, 4, rd, err);
      check("hold_rd", rd, 32'h1111_2222);

      // Abort during the wait window.
      sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h7000_0002; pwdata = 32'h55;
      tick();
      penable = 1'b1;
      tick(); tick();
      psel = 1'b0; penable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_pready", pready3, 1'b0);
      end
      ref_access(1'b1, 1'b0, 32'h7000_0002, 32'd0, mrd, merr);
      xfer(1'b1, 1'b0, 32'h7000_0002, 32'd0, 0, rd, err);
      check("abort_reg2", rd, mrd);

      // Randomized traffic against the reference arrays.
      for (int t = 0; t < 60; t++) begin
         bit          s, wr;
         int          r;
         logic [31:0] a, d;
         s  = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         d  = $urandom;
         r  = $urandom_range(0, 9);
         if (r < 7)       a = 32'h7000_0000 + $urandom_range(0, 15);
         else if (r == 7) a = 32'h7000_0000 + $urandom_range(16, 4095);
         else if (r == 8) a = $urandom;
         else             a = 32'h6000_0000 + $urandom_range(0, 15);
         ref_access(s, wr, a, d, mrd, merr);
         xfer(s, wr, a, d, $urandom_range(0, 2), rd, err);
         check($sformatf("rnd%0d_err", t), err, merr);
         if (!wr) check($sformatf("rnd%0d_rdata", t), rd, mrd);
      end

      // Final sweep of both instances.
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 16; i++) begin
            xfer(1'(s), 1'b0, 32'h7000_0000 + i, 32'd0, 0, rd, err);
            check($sformatf("sweep%0d_%0d", s, i), rd, mdl[s][i]);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
